// File: rtl/ext_bus_pkg.sv
// External bus controller shared definitions: FSM states, memory-space codes,
// idle (deasserted) values of the active-low pad controls and a select decoder.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GRANT  = 3'd4
  } state_t;

  // Memory space codes as carried on REQ_SP.
  localparam logic [1:0] SP_PM = 2'd0;
  localparam logic [1:0] SP_DM = 2'd1;
  localparam logic [1:0] SP_BM = 2'd2;
  localparam logic [1:0] SP_IO = 2'd3;

  // Active-low select and strobe pads, kept together as one registered bundle.
  typedef struct packed {
    logic pms_n;
    logic dms_n;
    logic bms_n;
    logic ios_n;
    logic rd_n;
    logic wr_n;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_CTL_IDLE = '{
    pms_n: 1'b1, dms_n: 1'b1, bms_n: 1'b1, ios_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1
  };
  localparam logic BG_IDLE = 1'b1;

  // Data pad output enables, ordered {15, 14_8, 7_0}.
  localparam logic [2:0] ED_OE_NONE = 3'b000;
  localparam logic [2:0] ED_OE_BYTE = 3'b001;
  localparam logic [2:0] ED_OE_ALL  = 3'b111;

  // Idle control bundle with the select for the given space pulled low.
  function automatic bus_ctl_t ctl_select(input logic [1:0] sp);
    bus_ctl_t c;
    c = BUS_CTL_IDLE;
    case (sp)
      SP_PM:   c.pms_n = 1'b0;
      SP_DM:   c.dms_n = 1'b0;
      SP_BM:   c.bms_n = 1'b0;
      default: c.ios_n = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/brn_sync.sv
// Two-flop synchronizer for the asynchronous active-low external bus request.
// Latency: 2 clk from T_BRn edge to brs. Backpressure: none (level signal).
// Ports: clk, rst (sync, active-high), t_brn (async in), brs (synced, active-high).
module brn_sync (
  input  logic clk,
  input  logic rst,
  input  logic t_brn,
  output logic brs
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = t_brn;
    s2_d = s1_q;
  end

  // Both stages reset to the idle (no request) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign brs = ~s2_q;

endmodule

// File: rtl/ext_bus_ctl.sv
// External bus sequencer: turns one core request into select/strobe/address/data
// phases with per-space wait states, and grants the bus to an external master.
// Latency: WS+3 cycles per access, ACK in the last; REQ is held off (no ACK) while granted.
// Ports: DSPCLK/RST; REQ* core request; WS_* wait states; T_ED pad data in;
//        T_BRn async bus request; ACK/RDATA completion; pad controls, EA/ED drives, BGn.
module ext_bus_ctl
  import ext_bus_pkg::*;
#(
  parameter int WS_W = 3
) (
  input  logic            DSPCLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            REQ_WR,
  input  logic [1:0]      REQ_SP,
  input  logic [14:0]     REQ_A,
  input  logic [15:0]     REQ_D,
  input  logic [WS_W-1:0] WS_PM,
  input  logic [WS_W-1:0] WS_DM,
  input  logic [WS_W-1:0] WS_BM,
  input  logic [WS_W-1:0] WS_IO,
  input  logic [15:0]     T_ED,
  input  logic            T_BRn,
  output logic            ACK,
  output logic [15:0]     RDATA,
  output logic            PMSn,
  output logic            DMSn,
  output logic            BMSn,
  output logic            IOSn,
  output logic            RDn,
  output logic            WRn,
  output logic            EA_oe,
  output logic [14:0]     EA_do,
  output logic            ED_oe_15,
  output logic            ED_oe_14_8,
  output logic            ED_oe_7_0,
  output logic [15:0]     ED_do,
  output logic            BGn
);

  logic brs;

  brn_sync u_brn_sync (
    .clk   (DSPCLK),
    .rst   (RST),
    .t_brn (T_BRn),
    .brs   (brs)
  );

  state_t          state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [1:0]      sp_q, sp_d;
  logic            wr_q, wr_d;
  bus_ctl_t        ctl_q, ctl_d;
  logic            bg_n_q, bg_n_d;
  logic            ea_oe_q, ea_oe_d;
  logic [2:0]      ed_oe_q, ed_oe_d;
  logic [14:0]     ea_do_q, ea_do_d;
  logic [15:0]     ed_do_q, ed_do_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic [WS_W-1:0] ws_req;

  // Wait-state field of the space being requested; only used at acceptance.
  always_comb begin
    ws_req = WS_PM;
    case (REQ_SP)
      SP_PM:   ws_req = WS_PM;
      SP_DM:   ws_req = WS_DM;
      SP_BM:   ws_req = WS_BM;
      default: ws_req = WS_IO;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    wr_d    = wr_q;
    ea_do_d = ea_do_q;
    ed_do_d = ed_do_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        // External master has priority over a simultaneous core request.
        if (brs) begin
          state_d = ST_GRANT;
        end else if (REQ) begin
          state_d = ST_SETUP;
          sp_d    = REQ_SP;
          wr_d    = REQ_WR;
          ea_do_d = REQ_A;
          ed_do_d = REQ_D;
          cnt_d   = ws_req;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        // Counter holds WS on the first strobe cycle, so the strobe lasts WS+1.
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          if (!wr_q) begin
            rdata_d = (sp_q == SP_BM) ? {8'h00, T_ED[7:0]} : T_ED;
          end
        end else begin
          cnt_d = cnt_q - WS_W'(1);
        end
      end
      ST_HOLD:  state_d = ST_IDLE;
      ST_GRANT: if (!brs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Pad controls are registered, so they are decoded from the state being
    // entered; this keeps every output glitch-free and aligned to its phase.
    ctl_d   = BUS_CTL_IDLE;
    bg_n_d  = BG_IDLE;
    ea_oe_d = 1'b0;
    ed_oe_d = ED_OE_NONE;
    ack_d   = 1'b0;

    case (state_d)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        ctl_d   = ctl_select(sp_d);
        ea_oe_d = 1'b1;
        if (wr_d) begin
          ed_oe_d = (sp_d == SP_BM) ? ED_OE_BYTE : ED_OE_ALL;
        end
        // Strobe only in STROBE: select leads and trails it by one cycle.
        if (state_d == ST_STROBE) begin
          if (wr_d) ctl_d.wr_n = 1'b0;
          else      ctl_d.rd_n = 1'b0;
        end
        ack_d = (state_d == ST_HOLD);
      end
      ST_GRANT: bg_n_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sp_q    <= SP_PM;
      wr_q    <= 1'b0;
      ctl_q   <= BUS_CTL_IDLE;
      bg_n_q  <= BG_IDLE;
      ea_oe_q <= 1'b0;
      ed_oe_q <= ED_OE_NONE;
      ea_do_q <= '0;
      ed_do_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      wr_q    <= wr_d;
      ctl_q   <= ctl_d;
      bg_n_q  <= bg_n_d;
      ea_oe_q <= ea_oe_d;
      ed_oe_q <= ed_oe_d;
      ea_do_q <= ea_do_d;
      ed_do_q <= ed_do_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign PMSn       = ctl_q.pms_n;
  assign DMSn       = ctl_q.dms_n;
  assign BMSn       = ctl_q.bms_n;
  assign IOSn       = ctl_q.ios_n;
  assign RDn        = ctl_q.rd_n;
  assign WRn        = ctl_q.wr_n;
  assign BGn        = bg_n_q;
  assign EA_oe      = ea_oe_q;
  assign EA_do      = ea_do_q;
  assign ED_oe_15   = ed_oe_q[2];
  assign ED_oe_14_8 = ed_oe_q[1];
  assign ED_oe_7_0  = ed_oe_q[0];
  assign ED_do      = ed_do_q;
  assign RDATA      = rdata_q;
  assign ACK        = ack_q;

endmodule

// File: tb/tb_ext_bus_ctl.sv
// Self-checking bench for ext_bus_ctl: directed and random accesses, bus grant
// scenarios and mid-access reset, checked cycle by cycle against a phase model.
module tb_ext_bus_ctl;

  logic        DSPCLK = 1'b0;
  logic        RST, REQ, REQ_WR, T_BRn;
  logic [1:0]  REQ_SP;
  logic [14:0] REQ_A;
  logic [15:0] REQ_D, T_ED;
  logic [2:0]  WS_PM, WS_DM, WS_BM, WS_IO;
  logic        ACK, PMSn, DMSn, BMSn, IOSn, RDn, WRn, EA_oe;
  logic        ED_oe_15, ED_oe_14_8, ED_oe_7_0, BGn;
  logic [15:0] RDATA, ED_do;
  logic [14:0] EA_do;

  ext_bus_ctl #(.WS_W(3)) dut (
    .DSPCLK(DSPCLK), .RST(RST), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_SP(REQ_SP),
    .REQ_A(REQ_A), .REQ_D(REQ_D), .WS_PM(WS_PM), .WS_DM(WS_DM), .WS_BM(WS_BM),
    .WS_IO(WS_IO), .T_ED(T_ED), .T_BRn(T_BRn), .ACK(ACK), .RDATA(RDATA),
    .PMSn(PMSn), .DMSn(DMSn), .BMSn(BMSn), .IOSn(IOSn), .RDn(RDn), .WRn(WRn),
    .EA_oe(EA_oe), .EA_do(EA_do), .ED_oe_15(ED_oe_15), .ED_oe_14_8(ED_oe_14_8),
    .ED_oe_7_0(ED_oe_7_0), .ED_do(ED_do), .BGn(BGn)
  );

  always #5 DSPCLK = ~DSPCLK;

  // {PMSn,DMSn,BMSn,IOSn,RDn,WRn,EA_oe,ED_oe_15,ED_oe_14_8,ED_oe_7_0,ACK,BGn}
  logic [11:0] obs_ctl;
  assign obs_ctl = {PMSn, DMSn, BMSn, IOSn, RDn, WRn, EA_oe,
                    ED_oe_15, ED_oe_14_8, ED_oe_7_0, ACK, BGn};

  localparam logic [11:0] CTL_IDLE  = 12'hFC1;
  localparam logic [11:0] CTL_GRANT = 12'hFC0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  cur_sp;
  logic        cur_wr;
  logic [14:0] cur_a;
  logic [15:0] cur_d, cur_ted;
  int          cur_ws;
  logic [15:0] exp_rdata = 16'h0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Expected pad controls in cycle k after acceptance (k=1 is the first cycle
  // after the accepting edge): select for cycles 1..WS+3, strobe for 2..WS+2,
  // ACK in WS+3, idle otherwise.
  function automatic logic [11:0] exp_ctl(input logic [1:0] sp, input logic wr,
                                          input int ws, input int k);
    logic       sel, stb;
    logic [3:0] s_n;
    logic [2:0] oe;
    sel = (k >= 1) && (k <= ws + 3);
    stb = (k >= 2) && (k <= ws + 2);
    s_n = 4'b1111;
    if (sel) s_n[sp] = 1'b0;
    oe  = (sel && wr) ? ((sp == 2'd2) ? 3'b001 : 3'b111) : 3'b000;
    return {s_n[0], s_n[1], s_n[2], s_n[3], !(stb && !wr), !(stb && wr),
            sel, oe, (k == ws + 3), 1'b1};
  endfunction

  task automatic rand_ws();
    WS_PM = 3'($urandom); WS_DM = 3'($urandom);
    WS_BM = 3'($urandom); WS_IO = 3'($urandom);
  endtask

  // Called at a negedge: request is taken by the next edge if the bus is idle.
  task automatic start_req(input logic [1:0] sp, input logic wr, input logic [14:0] a,
                           input logic [15:0] d, input logic [15:0] ted);
    cur_sp = sp; cur_wr = wr; cur_a = a; cur_d = d; cur_ted = ted;
    case (sp)
      2'd0:    cur_ws = int'(WS_PM);
      2'd1:    cur_ws = int'(WS_DM);
      2'd2:    cur_ws = int'(WS_BM);
      default: cur_ws = int'(WS_IO);
    endcase
    REQ = 1'b1; REQ_SP = sp; REQ_WR = wr; REQ_A = a; REQ_D = d;
    T_ED = 16'($urandom);
  endtask

  // Follows an access accepted at the coming edge. T_ED carries the real read
  // value only during the last strobe cycle; WS fields are scrambled after
  // acceptance; T_BRn optionally falls in cycle brn_at.
  task automatic track(input int brn_at);
    int n;
    n = cur_ws + 3;
    for (int k = 1; k <= n; k++) begin
      @(negedge DSPCLK);
      chk($sformatf("ctl sp%0d wr%0d ws%0d k%0d", cur_sp, cur_wr, cur_ws, k),
          64'(obs_ctl), 64'(exp_ctl(cur_sp, cur_wr, cur_ws, k)));
      chk($sformatf("ea_do k%0d", k), 64'(EA_do), 64'(cur_a));
      if (cur_wr) chk($sformatf("ed_do k%0d", k), 64'(ED_do), 64'(cur_d));
      if (k == n) begin
        if (!cur_wr) exp_rdata = (cur_sp == 2'd2) ? {8'h00, cur_ted[7:0]} : cur_ted;
        chk("rdata at ack", 64'(RDATA), 64'(exp_rdata));
        REQ = 1'b0;
      end
      if (k == 1) rand_ws();
      if (k == brn_at) T_BRn = 1'b0;
      T_ED = (k == cur_ws + 2) ? cur_ted : 16'($urandom);
    end
    @(negedge DSPCLK);
    chk("idle after access", 64'(obs_ctl), 64'(exp_ctl(cur_sp, cur_wr, cur_ws, n + 1)));
  endtask

  // Release the bus: BGn stays low two more cycles, rises in the third, and a
  // pending request is accepted at the end of that cycle.
  task automatic release_and_accept();
    T_BRn = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge DSPCLK);
      chk($sformatf("release j%0d", j), 64'(obs_ctl),
          64'((j < 3) ? CTL_GRANT : CTL_IDLE));
    end
    track(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; REQ_WR = 1'b0; REQ_SP = 2'd0; REQ_A = '0; REQ_D = '0;
    T_ED = '0; T_BRn = 1'b1;
    WS_PM = '0; WS_DM = '0; WS_BM = '0; WS_IO = '0;
    repeat (3) @(negedge DSPCLK);
    chk("reset state", 64'({obs_ctl, EA_do, ED_do, RDATA}),
        64'({CTL_IDLE, 15'h0, 16'h0, 16'h0}));
    RST = 1'b0;
    @(negedge DSPCLK);
    chk("idle after reset", 64'(obs_ctl), 64'(CTL_IDLE));

    // DM read, zero wait states.
    WS_DM = 3'd0;
    start_req(2'd1, 1'b0, 15'h0042, 16'h0000, 16'hA5C3);
    track(0);

    // PM write, seven wait states.
    WS_PM = 3'd7;
    start_req(2'd0, 1'b1, 15'h1234, 16'hBEEF, 16'h0000);
    track(0);

    // BM write then BM read with zero-extension.
    WS_BM = 3'd2;
    start_req(2'd2, 1'b1, 15'h0155, 16'h3C5A, 16'h0000);
    track(0);
    WS_BM = 3'd1;
    start_req(2'd2, 1'b0, 15'h0777, 16'h0000, 16'hFF7E);
    track(0);

    // Random accesses.
    for (int i = 0; i < 30; i++) begin
      rand_ws();
      start_req(2'($urandom), 1'($urandom), 15'($urandom), 16'($urandom), 16'($urandom));
      track(0);
    end

    // Bus request during the strobe of an IO read: access completes, then grant.
    WS_IO = 3'd3;
    start_req(2'd3, 1'b0, 15'h0A0A, 16'h0000, 16'h5AA5);
    track(2);
    @(negedge DSPCLK);
    chk("grant after io", 64'(obs_ctl), 64'(CTL_GRANT));
    repeat (2) begin
      @(negedge DSPCLK);
      chk("grant held", 64'(obs_ctl), 64'(CTL_GRANT));
    end
    WS_DM = 3'd2;
    start_req(2'd1, 1'b1, 15'h2222, 16'hC0DE, 16'h0000);
    repeat (2) begin
      @(negedge DSPCLK);
      chk("req ignored in grant", 64'(obs_ctl), 64'(CTL_GRANT));
    end
    release_and_accept();

    // Request and synchronized bus request in the same cycle: grant wins.
    T_BRn = 1'b0;
    @(negedge DSPCLK);
    chk("sync delay 1", 64'(obs_ctl), 64'(CTL_IDLE));
    @(negedge DSPCLK);
    chk("sync delay 2", 64'(obs_ctl), 64'(CTL_IDLE));
    WS_PM = 3'd1;
    start_req(2'd0, 1'b0, 15'h7FFF, 16'h0000, 16'h1357);
    repeat (2) begin
      @(negedge DSPCLK);
      chk("grant beats req", 64'(obs_ctl), 64'(CTL_GRANT));
    end
    release_and_accept();

    // Reset in the middle of the strobe drops the access.
    WS_PM = 3'd4;
    start_req(2'd0, 1'b1, 15'h0F0F, 16'h9876, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge DSPCLK);
      chk($sformatf("pre-reset k%0d", k), 64'(obs_ctl),
          64'(exp_ctl(cur_sp, cur_wr, cur_ws, k)));
    end
    RST = 1'b1;
    REQ = 1'b0;
    @(negedge DSPCLK);
    exp_rdata = 16'h0000;
    chk("reset mid strobe", 64'({obs_ctl, EA_do, ED_do, RDATA}),
        64'({CTL_IDLE, 15'h0, 16'h0, 16'h0}));
    RST = 1'b0;
    repeat (3) begin
      @(negedge DSPCLK);
      chk("no ack after reset", 64'(obs_ctl), 64'(CTL_IDLE));
    end
    WS_DM = 3'd3;
    start_req(2'd1, 1'b0, 15'h0123, 16'h0000, 16'hCAFE);
    track(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_bus_ctl.md
# ext_bus_ctl

External memory interface sequencer and bus-grant arbiter for the DSP core. It turns single core access requests into timed select, strobe, address and data-enable sequences on the external bus pads, with a programmable wait-state count per memory space. It also arbitrates the bus between the core and an external master (BRn/BGn). The block sits between the core memory/IO access logic and the pad ring, and drives PMSn, DMSn, BMSn, IOSn, RDn, WRn, EA_oe, EA_do, ED_oe_*, ED_do and BGn.

## Interface
Parameters:
- WS_W, 3: width of each wait-state field.

Ports:
- DSPCLK  in  1  core clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  core access request; held until ACK.
- REQ_WR  in  1  1 = write, 0 = read; stable while REQ is high.
- REQ_SP  in  2  space: 0 = PM, 1 = DM, 2 = BM (byte), 3 = IO.
- REQ_A  in  15  address; stable while REQ is high.
- REQ_D  in  16  write data; stable while REQ is high.
- WS_PM, WS_DM, WS_BM, WS_IO  in  WS_W each  wait states per space.
- T_ED  in  16  pad input data.
- T_BRn  in  1  asynchronous external bus request, active-low.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  16  read data; holds until the next read completes.
- PMSn, DMSn, BMSn, IOSn, RDn, WRn  out  1 each  active-low bus controls.
- EA_oe  out  1  address output enable.
- EA_do  out  15  address.
- ED_oe_15, ED_oe_14_8, ED_oe_7_0  out  1 each  data output enables.
- ED_do  out  16  write data.
- BGn  out  1  bus grant, active-low.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GRANT.
- Reset values: state IDLE. All selects, RDn, WRn and BGn are 1. EA_oe and all ED_oe are 0. EA_do, ED_do and RDATA are 0. ACK is 0. Wait counter is 0.
- T_BRn passes through a 2-flop synchronizer (reset value 1). BRs is the synchronized, inverted request.
- IDLE:
  - If BRs=1, go to GRANT. External requests win over REQ in the same cycle.
  - Else if REQ=1, latch REQ_SP, REQ_WR, REQ_A and REQ_D, load the wait counter from the selected WS field, and go to SETUP.
- SETUP (1 cycle):
  - The selected xxxSn goes low.
  - EA_oe=1 and EA_do = latched address.
  - On a write, ED_oe is enabled per space. BM drives only ED_oe_7_0. All other spaces drive all three enables.
- STROBE (WS+1 cycles):
  - RDn or WRn is low.
  - The counter decrements each cycle. The state exits when the counter reads 0.
  - On a read, T_ED is captured on the exit cycle. BM zero-extends T_ED[7:0].
- HOLD (1 cycle):
  - Strobe returns high. Select, address and write data stay driven.
  - ACK=1; RDATA is updated on reads.
  - Next state is IDLE.
- GRANT:
  - BGn=0. All selects and strobes are 1. EA_oe and ED_oe are 0.
  - Stays while BRs=1. On BRs=0, BGn returns to 1 and the state goes to IDLE.
- A bus request arriving mid-access never aborts it. It is serviced at the next IDLE.
- RST asserted in any state forces all reset values on the next edge. An in-flight access is dropped without ACK.
- WS fields are sampled only at acceptance. Changes during an access have no effect.

## Timing
- Accept at edge 0 (IDLE→SETUP).
- Total access = WS+3 cycles.
- ACK is high during cycle WS+3 after acceptance.
- The earliest next acceptance is the cycle after ACK. IDLE lasts at least 1 cycle between accesses.
- Grant latency from T_BRn falling: 2 synchronizer cycles, plus the remaining access cycles, plus 1 cycle.
- Release: BGn rises 3 cycles after T_BRn rises.
- RDn/WRn never overlap a select transition. Select leads the strobe by 1 cycle and trails it by 1 cycle.

## Structure
- A shared package ext_bus_pkg holds:
  - the state enumeration;
  - space codes SP_PM, SP_DM, SP_BM, SP_IO;
  - the idle-value constants for the bus controls.
- One sub-module, brn_sync: the 2-flop synchronizer for T_BRn. The FSM, wait counter and output registers live in the top. All outputs are registered.

## Test plan
- DM read, WS_DM=0, T_ED=16'hA5C3:
  - DMSn low for 3 cycles, RDn low for 1 cycle.
  - ACK in cycle 3; RDATA=16'hA5C3.
- PM write, WS_PM=7, A=15'h1234, D=16'hBEEF:
  - WRn low for 8 cycles; ACK in cycle 10.
  - EA_do=15'h1234, ED_do=16'hBEEF, all ED_oe high.
- BM write:
  - only ED_oe_7_0 is high.
- BM read with T_ED=16'hFF7E:
  - RDATA=16'h007E.
- T_BRn low during the STROBE of an IO access with WS_IO=3:
  - the access completes with ACK.
  - BGn goes low afterward with all enables 0.
  - T_BRn high → BGn high 3 cycles later; a pending REQ is then accepted.
- REQ and T_BRn asserted together while idle:
  - GRANT is taken first; REQ is accepted only after release.
- RST pulsed during STROBE:
  - all outputs at reset values on the next cycle; no ACK.
  - a new REQ afterward completes normally.
